// File: rtl/sevenseg_disp_arb.sv
// sevenseg_disp_arb: shares the 8-digit seven-segment datapath between NREQ
// requesters. Round-robin grant with minimum/maximum dwell times and a
// one-cycle blank gap between owners.
// Optional feature macro: SEVENSEG_DISP_ARB_PRIO0_EN
// (requester 0 gets absolute priority and preempts other owners after MIN_DWELL).
module sevenseg_disp_arb #(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned MIN_DWELL  = 1024,
  parameter int unsigned MAX_DWELL  = 65536,
  parameter logic [6:0]  BLANK_CODE = 7'h00
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*56-1:0]      digits_in,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic                    busy,
  output logic [6:0]              d0,
  output logic [6:0]              d1,
  output logic [6:0]              d2,
  output logic [6:0]              d3,
  output logic [6:0]              d4,
  output logic [6:0]              d5,
  output logic [6:0]              d6,
  output logic [6:0]              d7
);

  localparam int unsigned DIG_W     = 7;
  localparam int unsigned NDIG      = 8;
  localparam int unsigned SLICE_W   = DIG_W * NDIG;
  localparam int unsigned IDX_W     = $clog2(NREQ);
  localparam int unsigned DWELL_TOP = (MAX_DWELL > MIN_DWELL) ? MAX_DWELL : MIN_DWELL;
  localparam int unsigned TMR_W     = $clog2(DWELL_TOP + 1);
  localparam logic [TMR_W-1:0] MIN_M1 = TMR_W'(MIN_DWELL - 1);
  localparam logic [TMR_W-1:0] MAX_M1 = TMR_W'((MAX_DWELL == 0) ? 0 : (MAX_DWELL - 1));

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [NREQ-1:0]    gnt_q, gnt_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic               busy_q, busy_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [DIG_W-1:0]   dig_q [NDIG];
  logic [DIG_W-1:0]   dig_d [NDIG];

  logic [DIG_W-1:0]   slot_c [NREQ][NDIG];
  logic               win_vld_c;
  logic [IDX_W-1:0]   win_idx_c;
  logic               own_req_c;
  logic               other_req_c;
  logic               exit_c;

  // Unpack the flat digit bus into per-requester, per-digit codes
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
    for (genvar gk = 0; gk < NDIG; gk++) begin : g_dig
      assign slot_c[gi][gk] = digits_in[gi*SLICE_W + gk*DIG_W +: DIG_W];
    end
  end

  // Round-robin winner search starting after the last owner
  always_comb begin
    logic [IDX_W-1:0] cand;
    win_vld_c = 1'b0;
    win_idx_c = '0;
    cand      = '0;
`ifdef SEVENSEG_DISP_ARB_PRIO0_EN
    if (req[0]) begin
      win_vld_c = 1'b1;
      win_idx_c = '0;
    end
`endif
    for (int unsigned i = 1; i <= NREQ; i++) begin
      cand = IDX_W'((32'(last_q) + i) % NREQ);
      if (!win_vld_c && req[cand]) begin
        win_vld_c = 1'b1;
        win_idx_c = cand;
      end
    end
  end

  // HOLD exit decision: owner released after min dwell, or preempted
  always_comb begin
    own_req_c   = req[owner_q];
    other_req_c = |(req & ~gnt_q);
    exit_c      = (!own_req_c && (tmr_q >= MIN_M1)) ||
                  ((MAX_DWELL != 0) && (tmr_q >= MAX_M1) && other_req_c);
`ifdef SEVENSEG_DISP_ARB_PRIO0_EN
    if ((owner_q != '0) && req[0] && (tmr_q >= MIN_M1)) begin
      exit_c = 1'b1;
    end
`endif
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (win_vld_c) state_d = ST_HOLD;
      ST_HOLD: if (exit_c)    state_d = ST_GAP;
      ST_GAP:  state_d = win_vld_c ? ST_HOLD : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output/datapath next values
  always_comb begin
    gnt_d   = gnt_q;
    owner_d = owner_q;
    last_d  = last_q;
    busy_d  = busy_q;
    tmr_d   = tmr_q;
    dig_d   = dig_q;
    case (state_q)
      ST_HOLD: begin
        if (exit_c) begin
          gnt_d  = '0;
          busy_d = 1'b0;
          dig_d  = '{default: BLANK_CODE};
        end else begin
          tmr_d = (&tmr_q) ? tmr_q : tmr_q + TMR_W'(1);
          if (own_req_c) dig_d = slot_c[owner_q];
        end
      end
      default: begin
        gnt_d  = '0;
        busy_d = 1'b0;
        tmr_d  = '0;
        dig_d  = '{default: BLANK_CODE};
        if (win_vld_c) begin
          gnt_d   = NREQ'(1) << win_idx_c;
          busy_d  = 1'b1;
          owner_d = win_idx_c;
          last_d  = win_idx_c;
          dig_d   = slot_c[win_idx_c];
        end
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt_q   <= '0;
      owner_q <= '0;
      last_q  <= IDX_W'(NREQ - 1);
      busy_q  <= 1'b0;
      tmr_q   <= '0;
      dig_q   <= '{default: BLANK_CODE};
    end else begin
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      tmr_q   <= tmr_d;
      dig_q   <= dig_d;
    end
  end

  assign gnt   = gnt_q;
  assign owner = owner_q;
  assign busy  = busy_q;
  assign d0    = dig_q[0];
  assign d1    = dig_q[1];
  assign d2    = dig_q[2];
  assign d3    = dig_q[3];
  assign d4    = dig_q[4];
  assign d5    = dig_q[5];
  assign d6    = dig_q[6];
  assign d7    = dig_q[7];

endmodule

// File: doc/sevenseg_disp_arb.md
# sevenseg_disp_arb

- Shares the 8-digit seven-segment display datapath between `NREQ` requesters.
- Each requester presents eight 7-bit digit codes and raises a request.
- The block grants one owner at a time, round-robin, with minimum and maximum dwell times. Between owners it inserts a blank gap.
- It drives the `d0`..`d7` digit inputs of `sevenseg_ctl`.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 2..8.
- `MIN_DWELL`, 1024: minimum grant length in cycles, ≥1.
- `MAX_DWELL`, 65536: grant length after which a pending other requester preempts the owner. 0 disables preemption. Must be ≥ `MIN_DWELL` when non-zero.
- `BLANK_CODE`, 7'h00: digit code driven when no requester owns the display.

Ports:
- `clk`, input, 1: system clock; all logic on the rising edge.
- `rst_n`, input, 1: synchronous, active-low reset.
- `req`, input, `NREQ`: request per requester, level-sensitive.
- `digits_in`, input, `NREQ*56`: requester `i` occupies bits `[i*56 +: 56]`. Digit `k` is at `[i*56 + k*7 +: 7]`.
- `gnt`, output, `NREQ`: one-hot grant, registered.
- `owner`, output, `$clog2(NREQ)`: index of the current or last owner.
- `busy`, output, 1: high whenever `gnt` is non-zero.
- `d0`..`d7`, output, 7 each: digit codes to `sevenseg_ctl`, registered.

## Operation
States: IDLE, HOLD, GAP.

IDLE:
- `gnt`=0, all digits = `BLANK_CODE`.
- If any `req` is high, select the winner by round-robin and go to HOLD next cycle.

HOLD:
- `gnt[owner]`=1.
- Dwell counter `tmr` starts at 0 on the first HOLD cycle and saturates at its maximum value.
- While `req[owner]`=1, digits load from the owner's `digits_in` slice every cycle.
- While `req[owner]`=0, digits are frozen at the last loaded values.
- Exit to GAP when either:
  - `req[owner]`=0 and `tmr` ≥ `MIN_DWELL`-1; or
  - `MAX_DWELL`≠0, `tmr` ≥ `MAX_DWELL`-1, and any other `req` is high.
- The owner keeping `req` high with no other requester pending holds the display indefinitely.

GAP:
- Lasts exactly 1 cycle; `gnt`=0, digits = `BLANK_CODE`.
- Then go to HOLD with a new round-robin winner if any `req` is high, otherwise to IDLE.

Round-robin:
- Pointer `last` = index of the most recent owner.
- The winner is the first requester with `req` high, searching from `last`+1 upward and wrapping modulo `NREQ`.
- The previous owner can win again only if no other requester is pending.
- `last` updates on entry to HOLD.

Counter width: `$clog2(max(MIN_DWELL, MAX_DWELL)+1)` bits; no wrap.

## Timing
Reset values:
- state = IDLE, `gnt`=0, `busy`=0, `owner`=0.
- `last` = `NREQ`-1, so requester 0 wins first.
- all `d*` = `BLANK_CODE`; `tmr`=0.

Latency:
- `req` rise in IDLE → `gnt` high on the next edge (1 cycle).
- First digits valid on the same edge as `gnt`, loaded from `digits_in` sampled at that edge.
- `digits_in` change during HOLD → `d*` updated 1 cycle later.

Minimum HOLD duration is `MIN_DWELL` cycles, even if `req` drops on the first cycle.

Simultaneous events:
- Several requests in the same cycle: round-robin decides.
- A request arriving in the GAP cycle is eligible for that GAP's decision.
- Owner drop and the preemption condition in the same cycle: a single transition to GAP.

Reset mid-operation: `rst_n` low at any edge forces all reset values on that edge regardless of state.

Requesters must not assume a grant; they hold `req` until they see `gnt`.

## Configuration
Macro: `SEVENSEG_DISP_ARB_PRIO0_EN`.

Defined:
- Requester 0 has absolute priority. Whenever `req[0]` is high it wins every IDLE/GAP decision.
- While another requester owns the display, `req[0]` preempts it once `tmr` ≥ `MIN_DWELL`-1, regardless of `MAX_DWELL`.
- Round-robin applies only among requesters 1..`NREQ`-1.

Undefined: pure round-robin as described in Operation.

## Test plan
Parameters for all scenarios: `NREQ`=4, `MIN_DWELL`=4, `MAX_DWELL`=16.

1. Reset, then `req`=4'b0001 with requester 0 digits = 7'h01..7'h08:
   - `gnt`=4'b0001 one cycle after `req`.
   - `d0`..`d7` = 01..08; `busy`=1.
2. `req[0]` pulsed for 1 cycle:
   - `gnt` stays high exactly 4 cycles.
   - Then one GAP cycle with digits = `BLANK_CODE`.
   - Then IDLE.
3. `req`=4'b1111 held constant:
   - Grants rotate 0→1→2→3→0.
   - Each HOLD lasts 16 cycles, separated by 1-cycle gaps.
4. Owner 2 holding; `req[1]` and `req[3]` rise together at `tmr`=10:
   - GAP at `tmr`=15.
   - Then requester 3 wins (search starts from 3), then requester 1.
5. `rst_n`=0 for 1 cycle mid-HOLD:
   - Next edge: `gnt`=0, digits = `BLANK_CODE`.
   - With all `req` high, requester 0 wins next.
6. With `SEVENSEG_DISP_ARB_PRIO0_EN` defined, owner 2 holding and `req[0]` rising at `tmr`=1:
   - GAP after `tmr`=3, then `gnt`=4'b0001.
